instruction_fetch: RTL and testbench

//  IF stage of the 5-stage MIPS/DLX pipeline; producer of the 32-bit instruction word consumed by ID.

---
 rtl/instruction_fetch.sv | 166 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage: holds the PC, fetches over a req/ack handshake and loads the IF/ID register.
// Define IF_PERF_CNT_EN to add the perf_fetched/perf_stall counter outputs.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        load_en;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        unused_tgt_bits;

  assign pc_plus4        = pc_q + 32'd4;
  assign target          = {branch_target[31:2], 2'b00};
  assign unused_tgt_bits = &{1'b0, branch_target[1:0]};

  // In DRAIN the PC still holds the address of the outstanding request.
  assign imem_req       = rst_n && (state_q != HOLD);
  assign imem_addr      = pc_q;
  assign if_id_instruc  = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    load_en = 1'b0;

    if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    unique case (state_q)
      FETCH: begin
        if (branch_taken) begin
          if (imem_ack) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (!stall) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            load_en = 1'b1;
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = hold_q;
          pc4_d   = pc_q;
          valid_d = 1'b1;
          load_en = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) redir_d = target;
        if (imem_ack) begin
          pc_d    = branch_taken ? target : redir_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // A redirect flushes IF/ID and the hold buffer regardless of stall.
    if (branch_taken) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      hold_d  = NOP_INSTR;
      load_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      hold_q  <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, load_en};
    perf_stall_d   = perf_stall_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a wait-state-configurable memory model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  int wait_states = 0;
  int wait_cnt;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_id_instruc  (if_id_instruc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers after wait_states cycles of an outstanding request.
  assign imem_ack   = imem_req && (wait_cnt >= wait_states);
  assign imem_rdata = imem_addr | 32'hA000_0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wait_cnt <= 0;
    else if (imem_ack) wait_cnt <= 0;
    else if (imem_req) wait_cnt <= wait_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic br, input logic [31:0] tgt);
    stall         = s;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    #1;
    stall        = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic checkIfId(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
    checkOutput({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    checkOutput({tag, "_instr"}, if_id_instruc, ins);
    checkOutput({tag, "_pc4"}, if_id_pc_plus4, p4);
  endtask

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkIfId("reset", 1'b0, 32'h0, 32'h0);
    checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
    checkOutput("reset_perf_f", perf_fetched, 32'd0);
    checkOutput("reset_perf_s", perf_stall, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);

    // Zero-wait streaming.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkIfId("stream", 1'b1, 32'hA000_0000 | (32'(i - 1) * 4), 32'(i) * 4);
    end
    checkOutput("stream_addr", imem_addr, 32'h10);

    // Stall during the ack at 0x10 parks the word in the hold buffer.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkIfId("stall_frozen", 1'b1, 32'hA000_000C, 32'h10);
      checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("release", 1'b1, 32'hA000_0010, 32'h14);
    checkOutput("release_addr", imem_addr, 32'h14);
    checkOutput("release_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("resume", 1'b1, 32'hA000_0014, 32'h18);

    // Redirect with ack in the same cycle.
    applyStimulus(1'b0, 1'b1, 32'h103);
    checkOutput("br_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("br_instr", if_id_instruc, 32'h0);
    checkOutput("br_addr", imem_addr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("br_fetch", 1'b1, 32'hA000_0100, 32'h104);

    // Branch while a slow fetch at 0x40 is outstanding.
    applyStimulus(1'b0, 1'b1, 32'h40);
    wait_states = 3;
    applyStimulus(1'b0, 1'b1, 32'h200);
    checkOutput("drain_addr0", imem_addr, 32'h40);
    checkOutput("drain_req0", {31'd0, imem_req}, 32'd1);
    checkOutput("drain_valid0", {31'd0, if_id_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("drain_addr1", imem_addr, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("drain_addr2", imem_addr, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("drain_done_addr", imem_addr, 32'h200);
    checkIfId("drain_discard", 1'b0, 32'h0, 32'h104);
    wait_states = 0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("drain_fetch", 1'b1, 32'hA000_0200, 32'h204);

    // Flush beats stall.
    applyStimulus(1'b1, 1'b1, 32'h80);
    checkOutput("flush_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("flush_addr", imem_addr, 32'h80);
    checkOutput("flush_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("flush_fetch", 1'b1, 32'hA000_0080, 32'h84);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
    checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0);
    checkOutput("wrap_addr1", imem_addr, 32'h0);

    // Asynchronous reset in the middle of a drain.
    wait_states = 3;
    applyStimulus(1'b0, 1'b1, 32'h300);
    checkOutput("pre_rst_addr", imem_addr, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_req", {31'd0, imem_req}, 32'd0);
    checkIfId("arst", 1'b0, 32'h0, 32'h0);
`ifdef IF_PERF_CNT_EN
    checkOutput("arst_perf_f", perf_fetched, 32'd0);
    checkOutput("arst_perf_s", perf_stall, 32'd0);
`endif
    @(posedge clk);
    #1;
    wait_states = 0;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_addr", imem_addr, 32'h0);
    checkOutput("post_rst_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkIfId("post_rst", 1'b1, 32'hA000_0000, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
